// File: rtl/sd_spi_engine_if.sv
// Host/card-facing signal bundle of the SD SPI command engine.
// master: host register block plus card pins; slave: the engine.
interface sd_spi_engine_if;
    logic        en_clk;
    logic [7:0]  div_value;
    logic [6:0]  cmd;
    logic [31:0] idata;
    logic        en;
    logic        miso;
    logic        sclk;
    logic        mosi;
    logic [6:0]  resp_status;
    logic [31:0] resp_long_status;
    logic        valid_status;
    logic        rdy;

    modport master (
        output en_clk, div_value, cmd, idata, en, miso,
        input  sclk, mosi, resp_status, resp_long_status, valid_status, rdy
    );

    modport slave (
        input  en_clk, div_value, cmd, idata, en, miso,
        output sclk, mosi, resp_status, resp_long_status, valid_status, rdy
    );
endinterface

// File: rtl/sd_spi_engine.sv
// SD-card SPI command engine: SCLK divider plus a command/response
// sequencer (48-bit command out, R1 in, optional 32-bit R3/R7 trailer).
module sd_spi_engine (
    input  logic            clk,
    input  logic            rst,
    sd_spi_engine_if.slave  bus
);

    typedef enum logic [2:0] {StIdle, StSend, StWait, StR1, StLong} state_e;

    state_e      state_q, state_d;

    logic [7:0]  div_cnt_q;
    logic        sclk_q;
    logic        sclk_prev_q;
    logic        sclk_rise;
    logic        sclk_fall;

    logic [47:0] tx_q;
    logic        mosi_q;
    logic [5:0]  bit_cnt_q;
    logic [5:0]  wait_cnt_q;
    logic [38:0] rx_q;
    logic [38:0] rx_next;
    logic [5:0]  cmd_idx_q;
    logic        armed_q;
    logic [6:0]  resp_status_q;
    logic [31:0] resp_long_q;
    logic        valid_q;
    logic        long_cmd;

    logic [39:0] frame_head;
    logic [47:0] frame;

    // FSM output strobes
    logic rdy;
    logic start;
    logic abort;
    logic shift_out;
    logic send_last;
    logic bit_step;
    logic wait_step;
    logic r1_start;
    logic timeout;
    logic r1_done;
    logic long_done;
    logic rx_step;

    // Bit 6 of cmd is reserved.
    logic unused_cmd_rsvd;
    assign unused_cmd_rsvd = bus.cmd[6];

    // CRC7, polynomial x^7 + x^3 + 1, initial value 0, MSB first.
    function automatic logic [6:0] crc7(input logic [39:0] data);
        logic [6:0] crc;
        logic       fb;
        crc = '0;
        for (int i = 39; i >= 0; i--) begin
            fb  = crc[6] ^ data[i];
            crc = {crc[5:0], 1'b0};
            if (fb) begin
                crc = crc ^ 7'h09;
            end
        end
        return crc;
    endfunction

    assign frame_head = {2'b01, bus.cmd[5:0], bus.idata};
    assign frame      = {frame_head, crc7(frame_head), 1'b1};

    assign long_cmd  = (cmd_idx_q == 6'd8) || (cmd_idx_q == 6'd58);
    assign rx_next   = {rx_q[37:0], bus.miso};
    assign sclk_rise = sclk_q & ~sclk_prev_q;
    assign sclk_fall = ~sclk_q & sclk_prev_q;

    // SCLK divider: toggle every div_value+1 clocks, parked low when disabled
    always_ff @(posedge clk) begin
        if (rst || !bus.en_clk) begin
            div_cnt_q <= '0;
            sclk_q    <= 1'b0;
        end else if (div_cnt_q == bus.div_value) begin
            div_cnt_q <= '0;
            sclk_q    <= ~sclk_q;
        end else begin
            div_cnt_q <= div_cnt_q + 8'd1;
        end
    end

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic driven by the decoded strobes
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = StSend;
        end
        if (send_last) begin
            state_d = StWait;
        end
        if (r1_start) begin
            state_d = StR1;
        end
        if (r1_done) begin
            state_d = long_cmd ? StLong : StIdle;
        end
        if (timeout || long_done || abort) begin
            state_d = StIdle;
        end
    end

    // Output/strobe decode; abort masks every in-flight action
    always_comb begin
        rdy       = (state_q == StIdle);
        start     = rdy && bus.en && !sclk_q && armed_q;
        abort     = !rdy && !bus.en;
        shift_out = !abort && (state_q == StSend) && sclk_fall;
        send_last = !abort && (state_q == StSend) && sclk_rise && (bit_cnt_q == 6'd47);
        bit_step  = !abort && sclk_rise &&
                    ((state_q == StSend) || (state_q == StR1) || (state_q == StLong));
        r1_start  = !abort && (state_q == StWait) && sclk_rise && !bus.miso;
        wait_step = !abort && (state_q == StWait) && sclk_rise && bus.miso;
        timeout   = wait_step && (wait_cnt_q == 6'd63);
        rx_step   = !abort && sclk_rise && ((state_q == StR1) || (state_q == StLong));
        r1_done   = rx_step && (state_q == StR1) && (bit_cnt_q == 6'd6);
        long_done = rx_step && (state_q == StLong) && (bit_cnt_q == 6'd31);
    end

    // Frame shifter, response capture and host-visible status
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_prev_q   <= 1'b0;
            tx_q          <= '0;
            mosi_q        <= 1'b1;
            bit_cnt_q     <= '0;
            wait_cnt_q    <= '0;
            rx_q          <= '0;
            cmd_idx_q     <= '0;
            armed_q       <= 1'b0;
            resp_status_q <= 7'h7F;
            resp_long_q   <= '0;
            valid_q       <= 1'b0;
        end else begin
            sclk_prev_q <= sclk_q;
            valid_q     <= 1'b0;

            // One request level yields one transaction.
            if (start) begin
                armed_q <= 1'b0;
            end else if (!bus.en) begin
                armed_q <= 1'b1;
            end

            if (start) begin
                tx_q       <= frame;
                mosi_q     <= frame[47];
                bit_cnt_q  <= '0;
                wait_cnt_q <= '0;
                cmd_idx_q  <= bus.cmd[5:0];
            end
            if (abort) begin
                mosi_q <= 1'b1;
            end

            if (shift_out) begin
                tx_q   <= {tx_q[46:0], 1'b0};
                mosi_q <= tx_q[46];
            end
            if (bit_step) begin
                bit_cnt_q <= bit_cnt_q + 6'd1;
            end
            if (send_last) begin
                mosi_q <= 1'b1;
            end
            if (send_last || r1_done) begin
                bit_cnt_q <= '0;
            end
            if (wait_step) begin
                wait_cnt_q <= wait_cnt_q + 6'd1;
            end

            // The R1 start bit is always 0 and is not kept.
            if (r1_start) begin
                rx_q <= '0;
            end else if (rx_step) begin
                rx_q <= rx_next;
            end

            if (timeout) begin
                resp_status_q <= 7'h7F;
                valid_q       <= 1'b1;
            end
            if (r1_done && !long_cmd) begin
                resp_status_q <= rx_next[6:0];
                valid_q       <= 1'b1;
            end
            if (long_done) begin
                resp_status_q <= rx_next[38:32];
                resp_long_q   <= rx_next[31:0];
                valid_q       <= 1'b1;
            end
        end
    end

    assign bus.sclk             = sclk_q;
    assign bus.mosi             = mosi_q;
    assign bus.rdy              = rdy;
    assign bus.valid_status     = valid_q;
    assign bus.resp_status      = resp_status_q;
    assign bus.resp_long_status = resp_long_q;

endmodule

// File: tb/tb_sd_spi_engine.sv
// Bench for sd_spi_engine: bit-level SD card model plus a response
// model computed from the raw MISO bit stream.
module tb_sd_spi_engine;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sd_spi_engine_if bus ();

    sd_spi_engine dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [6:0]  exp_resp;
    logic [31:0] exp_long;

    // Card model: bits it will return after the 48-bit command.
    bit          stream[$];
    int          card_cnt = 0;
    logic [47:0] card_frame = '0;
    logic        card_prev_sclk = 1'b0;
    logic        card_prev_rdy = 1'b1;

    always @(negedge clk) begin
        if (rst || bus.rdy !== 1'b0) begin
            bus.miso = 1'b1;
        end else begin
            if (card_prev_rdy) begin
                card_cnt = 0;
            end
            if (bus.sclk && !card_prev_sclk) begin
                card_cnt++;
                if (card_cnt <= 48) begin
                    card_frame = {card_frame[46:0], bus.mosi};
                end
            end
            if (!bus.sclk && card_prev_sclk && card_cnt >= 48) begin
                bus.miso = (card_cnt - 48 < int'(stream.size())) ? stream[card_cnt - 48] : 1'b1;
            end
        end
        card_prev_sclk = bus.sclk;
        card_prev_rdy  = (bus.rdy !== 1'b0);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit sbit(input int i);
        return (i < int'(stream.size())) ? stream[i] : 1'b1;
    endfunction

    // CRC7 as the remainder of msg * x^7 divided by x^7 + x^3 + 1.
    function automatic logic [6:0] crc7_ref(input logic [39:0] msg);
        logic [46:0] r;
        r = {msg, 7'b0};
        for (int i = 46; i >= 7; i--) begin
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        end
        return r[6:0];
    endfunction

    task automatic push_ones(input int n);
        repeat (n) stream.push_back(1'b1);
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) stream.push_back(b[i]);
    endtask

    task automatic run_txn(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                           input bit hold_en);
        logic [47:0] exp_frame;
        int          lead;
        int          exp_rises;
        bit          is_long;
        logic [39:0] head;

        head      = {2'b01, idx, arg};
        exp_frame = {head, crc7_ref(head), 1'b1};
        is_long   = (idx == 6'd8) || (idx == 6'd58);
        lead = 0;
        while (lead < 64 && sbit(lead)) lead++;
        if (lead >= 64) begin
            exp_resp  = 7'h7F;
            exp_rises = 48 + 64;
        end else begin
            for (int k = 1; k <= 7; k++) exp_resp = {exp_resp[5:0], sbit(lead + k)};
            exp_rises = 48 + lead + 8;
            if (is_long) begin
                for (int k = 0; k < 32; k++) exp_long = {exp_long[30:0], sbit(lead + 8 + k)};
                exp_rises += 32;
            end
        end

        bus.cmd   = {1'($urandom_range(0, 1)), idx};
        bus.idata = arg;
        bus.en    = 1'b0;
        tick(2);
        bus.en = 1'b1;
        for (int i = 0; i < 600 && bus.rdy; i++) tick(1);
        check({tag, "_start"}, bus.rdy, 1'b0);
        for (int i = 0; i < 6000; i++) begin
            tick(1);
            if (bus.valid_status) break;
        end
        check({tag, "_valid"}, bus.valid_status, 1'b1);
        check({tag, "_rdy_with_valid"}, bus.rdy, 1'b1);
        check({tag, "_frame"}, card_frame, exp_frame);
        check({tag, "_r1"}, bus.resp_status, exp_resp);
        check({tag, "_long"}, bus.resp_long_status, exp_long);
        check({tag, "_sclk_count"}, card_cnt, exp_rises);
        tick(1);
        check({tag, "_valid_width"}, bus.valid_status, 1'b0);
        if (!hold_en) bus.en = 1'b0;
    endtask

    task automatic measure_div(input logic [7:0] div);
        logic s[64];
        int   r0, r1, f;
        bus.div_value = div;
        bus.en_clk    = 1'b0;
        tick(2);
        bus.en_clk = 1'b1;
        for (int i = 0; i < 64; i++) begin
            tick(1);
            s[i] = bus.sclk;
        end
        r0 = -1; r1 = -1; f = -1;
        for (int i = 1; i < 64; i++) begin
            if (s[i] && !s[i-1]) begin
                if (r0 < 0) r0 = i;
                else if (r1 < 0) r1 = i;
            end
            if (!s[i] && s[i-1] && r0 >= 0 && f < 0) f = i;
        end
        check($sformatf("div%0d_period", div), r1 - r0, 2 * (int'(div) + 1));
        check($sformatf("div%0d_high", div), f - r0, int'(div) + 1);
    endtask

    initial begin
        int hi_cnt;
        int busy;
        int pulses;
        logic [5:0] idx;

        rst           = 1'b1;
        bus.en_clk    = 1'b1;
        bus.div_value = 8'd1;
        bus.cmd       = '0;
        bus.idata     = '0;
        bus.en        = 1'b0;
        tick(3);
        check("rst_sclk", bus.sclk, 1'b0);
        check("rst_mosi", bus.mosi, 1'b1);
        check("rst_rdy", bus.rdy, 1'b1);
        check("rst_valid", bus.valid_status, 1'b0);
        check("rst_resp", bus.resp_status, 7'h7F);
        check("rst_long", bus.resp_long_status, 32'h0);
        exp_resp = 7'h7F;
        exp_long = '0;
        rst = 1'b0;

        measure_div(8'd2);
        measure_div(8'd0);
        measure_div(8'd5);
        bus.en_clk = 1'b0;
        tick(1);
        hi_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (bus.sclk !== 1'b0) hi_cnt++;
        end
        check("div_off_low", hi_cnt, 0);
        bus.en_clk    = 1'b1;
        bus.div_value = 8'd2;

        // CMD0, card answers 0x01 after two 0xFF bytes.
        stream.delete();
        push_ones(16);
        push_byte(8'h01);
        run_txn("cmd0", 6'd0, 32'h0, 1'b0);
        check("cmd0_bytes", card_frame, 48'h40_0000_0000_95);
        check("cmd0_r1", bus.resp_status, 7'h01);

        // CMD8 with R7 trailer.
        stream.delete();
        push_ones(8);
        push_byte(8'h01); push_byte(8'h00); push_byte(8'h00);
        push_byte(8'h01); push_byte(8'hAA);
        run_txn("cmd8", 6'd8, 32'h0000_01AA, 1'b0);
        check("cmd8_bytes", card_frame, 48'h48_0000_01AA_87);
        check("cmd8_trailer", bus.resp_long_status, 32'h0000_01AA);

        // Card never answers.
        stream.delete();
        run_txn("timeout", 6'd17, 32'h1234_5678, 1'b0);
        check("timeout_r1", bus.resp_status, 7'h7F);

        // Single-shot: request level stays high after completion.
        stream.delete();
        push_ones(3);
        push_byte(8'h05);
        run_txn("shot", 6'd55, 32'hDEAD_BEEF, 1'b1);
        busy = 0;
        pulses = 0;
        for (int i = 0; i < 400; i++) begin
            tick(1);
            if (bus.rdy !== 1'b1) busy++;
            if (bus.valid_status !== 1'b0) pulses++;
        end
        check("shot_no_rerun", busy + pulses, 0);
        stream.delete();
        push_ones(1);
        push_byte(8'h00);
        run_txn("shot_rearm", 6'd13, 32'h0, 1'b0);

        // Abort mid-SEND.
        stream.delete();
        push_byte(8'h01);
        bus.cmd   = 7'd24;
        bus.idata = 32'hA5A5_0F0F;
        bus.en    = 1'b0;
        tick(2);
        bus.en = 1'b1;
        for (int i = 0; i < 600 && bus.rdy; i++) tick(1);
        for (int i = 0; i < 600 && card_cnt < 10; i++) tick(1);
        check("abort_in_send", bus.rdy, 1'b0);
        bus.en = 1'b0;
        tick(1);
        check("abort_rdy", bus.rdy, 1'b1);
        check("abort_mosi", bus.mosi, 1'b1);
        pulses = 0;
        for (int i = 0; i < 300; i++) begin
            tick(1);
            if (bus.valid_status !== 1'b0) pulses++;
        end
        check("abort_no_valid", pulses, 0);
        check("abort_resp_kept", bus.resp_status, exp_resp);

        // Reset mid-LONG.
        stream.delete();
        push_ones(3);
        push_byte(8'h01);
        push_byte(8'hC0); push_byte(8'hFF); push_byte(8'h80); push_byte(8'h00);
        bus.cmd   = 7'd58;
        bus.idata = 32'h0;
        bus.en    = 1'b0;
        tick(2);
        bus.en = 1'b1;
        for (int i = 0; i < 600 && bus.rdy; i++) tick(1);
        for (int i = 0; i < 3000 && card_cnt < 48 + 3 + 8 + 6; i++) tick(1);
        check("long_in_progress", bus.rdy, 1'b0);
        rst = 1'b1;
        tick(1);
        check("mid_rst_sclk", bus.sclk, 1'b0);
        check("mid_rst_mosi", bus.mosi, 1'b1);
        check("mid_rst_rdy", bus.rdy, 1'b1);
        check("mid_rst_valid", bus.valid_status, 1'b0);
        check("mid_rst_resp", bus.resp_status, 7'h7F);
        check("mid_rst_long", bus.resp_long_status, 32'h0);
        exp_resp = 7'h7F;
        exp_long = '0;
        rst    = 1'b0;
        bus.en = 1'b0;
        tick(2);

        // Randomised transactions against the stream model.
        for (int t = 0; t < 20; t++) begin
            bus.div_value = 8'($urandom_range(1, 3));
            case ($urandom_range(0, 3))
                0: idx = 6'd8;
                1: idx = 6'd58;
                default: idx = 6'($urandom_range(0, 63));
            endcase
            stream.delete();
            push_ones($urandom_range(0, 70));
            for (int k = 0; k < 48; k++) stream.push_back(1'($urandom_range(0, 1)));
            run_txn($sformatf("rnd%0d", t), idx, $urandom, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
